ov7670_frame_capture: RTL

Captures one RGB565 frame from the OV7670 parallel bus and writes it as 24-bit RGB888 pixels, row-major, into the frame memory that the 4x4 block-averaging compression stage reads. It sits directly upstream of the compression stage. On a complete frame it pulses `oframe_done`, which the control logic uses to launch compression. The block runs in the camera pixel-clock domain.

---
 rtl/ov7670_frame_capture.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ov7670_frame_capture.sv
// OV7670 RGB565 frame grabber: assembles byte pairs into RGB888 pixels and
// writes one armed frame row-major into frame memory, flagging done or error.
module ov7670_frame_capture #(
    parameter int pIM_WIDTH   = 640,
    parameter int pIM_HEIGHT  = 480,
    parameter int pOUT_DATA_W = 24,
    localparam int lpADDR_W   = $clog2(pIM_WIDTH*pIM_HEIGHT)
) (
    input  logic                   iclk,
    input  logic                   irst,
    input  logic                   ivsync,
    input  logic                   ihref,
    input  logic [7:0]             idata,
    input  logic                   istart_capture,
    output logic [pOUT_DATA_W-1:0] odata_wr,
    output logic [lpADDR_W-1:0]    oaddr_wr,
    output logic                   omem_wr_en,
    output logic                   obusy,
    output logic                   oframe_done,
    output logic                   oframe_err
);
    localparam int lpCOL_W = $clog2(pIM_WIDTH + 1);
    localparam int lpROW_W = $clog2(pIM_HEIGHT + 1);
    localparam logic [lpCOL_W-1:0] lpCOL_MAX = lpCOL_W'(pIM_WIDTH);
    localparam logic [lpROW_W-1:0] lpROW_MAX = lpROW_W'(pIM_HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_CHECK} state_t;
    state_t r_state, w_state_nxt;

    logic                   r_vs_s0, r_hr_s0, r_vs_d, r_hr_d;
    logic [7:0]             r_d_s0, r_byte_a;
    logic                   r_phase, r_short;
    logic [lpCOL_W-1:0]     r_col;
    logic [lpROW_W-1:0]     r_row;
    logic [lpADDR_W-1:0]    r_addr;
    logic [pOUT_DATA_W-1:0] r_pix;
    logic                   r_pix_vld;

    logic       w_vs_fall, w_vs_rise, w_hr_fall;
    logic [4:0] w_r5, w_b5;
    logic [5:0] w_g6;
    logic [23:0] w_rgb;

    assign w_vs_fall = !r_vs_s0 && r_vs_d;
    assign w_vs_rise = r_vs_s0 && !r_vs_d;
    assign w_hr_fall = !r_hr_s0 && r_hr_d;

    // Byte A is latched earlier; byte B is the current stage0 byte.
    assign w_r5  = r_byte_a[7:3];
    assign w_g6  = {r_byte_a[2:0], r_d_s0[7:5]};
    assign w_b5  = r_d_s0[4:0];
    assign w_rgb = {w_r5, w_r5[4:2], w_g6, w_g6[5:4], w_b5, w_b5[4:2]};

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (istart_capture) w_state_nxt = S_ARM;
            S_ARM:     if (w_vs_fall)      w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (w_vs_rise)      w_state_nxt = S_CHECK;
            S_CHECK:                       w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_vs_s0     <= 1'b0;
            r_hr_s0     <= 1'b0;
            r_d_s0      <= '0;
            r_vs_d      <= 1'b0;
            r_hr_d      <= 1'b0;
            r_byte_a    <= '0;
            r_phase     <= 1'b0;
            r_short     <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_pix       <= '0;
            r_pix_vld   <= 1'b0;
            odata_wr    <= '0;
            oaddr_wr    <= '0;
            omem_wr_en  <= 1'b0;
            obusy       <= 1'b0;
            oframe_done <= 1'b0;
            oframe_err  <= 1'b0;
        end else begin
            r_vs_s0 <= ivsync;
            r_hr_s0 <= ihref;
            r_d_s0  <= idata;
            r_vs_d  <= r_vs_s0;
            r_hr_d  <= r_hr_s0;

            obusy       <= (w_state_nxt != S_IDLE);
            oframe_done <= (r_state == S_CHECK) && (r_row == lpROW_MAX) && !r_short;
            oframe_err  <= (r_state == S_CHECK) && !((r_row == lpROW_MAX) && !r_short);

            // Write stage drains independently of the FSM so a pixel in flight
            // at the VSYNC rise still lands before CHECK.
            r_pix_vld  <= 1'b0;
            omem_wr_en <= r_pix_vld;
            if (r_pix_vld) begin
                odata_wr <= r_pix;
                oaddr_wr <= r_addr;
                r_addr   <= r_addr + 1'b1;
            end

            case (r_state)
                S_ARM: begin
                    r_row   <= '0;
                    r_col   <= '0;
                    r_phase <= 1'b0;
                    r_short <= 1'b0;
                    r_addr  <= '0;
                end
                S_CAPTURE: begin
                    if (r_hr_s0) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_byte_a <= r_d_s0;
                        end else begin
                            r_pix     <= pOUT_DATA_W'(w_rgb);
                            r_pix_vld <= (r_col < lpCOL_MAX) && (r_row < lpROW_MAX);
                            if (r_col != lpCOL_MAX) r_col <= r_col + 1'b1;
                        end
                    end else if (w_hr_fall) begin
                        r_phase <= 1'b0;
                        r_col   <= '0;
                        if (r_col == lpCOL_MAX) begin
                            if (r_row != lpROW_MAX) r_row <= r_row + 1'b1;
                        end else begin
                            r_short <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
